// File: rtl/dll_fc_init.sv
// rtl/dll_fc_init.sv - Data Link Layer flow-control initialization engine.
// Sends InitFC1/InitFC2 sequences, records partner credit limits, drives init1_end/init2_end.
module dll_fc_init #(
  parameter logic [7:0]  ADV_P_H    = 8'd32,
  parameter logic [11:0] ADV_P_D    = 12'd256,
  parameter logic [7:0]  ADV_NP_H   = 8'd32,
  parameter logic [11:0] ADV_NP_D   = 12'd0,
  parameter logic [7:0]  ADV_CPL_H  = 8'd0,
  parameter logic [11:0] ADV_CPL_D  = 12'd0,
  parameter int          RESEND_GAP = 16
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic [1:0]  dlcm_state_i,
  input  logic        rx_dllp_valid_i,
  input  logic [31:0] rx_dllp_i,
  input  logic        rx_tlp_i,
  output logic        tx_dllp_valid_o,
  output logic [31:0] tx_dllp_o,
  input  logic        tx_dllp_ready_i,
  output logic        init1_end_o,
  output logic        init2_end_o,
  output logic [7:0]  p_h_lim_o,
  output logic [7:0]  np_h_lim_o,
  output logic [7:0]  cpl_h_lim_o,
  output logic [11:0] p_d_lim_o,
  output logic [11:0] np_d_lim_o,
  output logic [11:0] cpl_d_lim_o
);

  localparam int GW = $clog2(RESEND_GAP + 1);

  typedef enum logic [1:0] {IDLE, FC1, FC2, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            seq_sent_q, seq_sent_d;
  logic            rx_p_q, rx_p_d, rx_np_q, rx_np_d, rx_cpl_q, rx_cpl_d;
  logic            fc2_seen_q, fc2_seen_d;
  logic            init1_q, init1_d, init2_q, init2_d;
  logic [7:0]      p_h_q, p_h_d, np_h_q, np_h_d, cpl_h_q, cpl_h_d;
  logic [11:0]     p_d_q, p_d_d, np_d_q, np_d_d, cpl_d_q, cpl_d_d;

  logic [7:0]      rx_type, rx_hdr, tx_type, tx_hdr;
  logic [11:0]     rx_data, tx_data;
  logic            tx_fire;
  logic            unused_bits;

  assign rx_type     = rx_dllp_i[31:24];
  assign rx_hdr      = rx_dllp_i[21:14];
  assign rx_data     = rx_dllp_i[11:0];
  assign unused_bits = ^{rx_dllp_i[23:22], rx_dllp_i[13:12]};

  assign tx_dllp_valid_o = ((state_q == FC1) || (state_q == FC2)) && (gap_q == '0);
  assign tx_fire         = tx_dllp_valid_o && tx_dllp_ready_i;

  // InitFC2 codes are the InitFC1 codes with bit 7 set.
  always_comb begin
    tx_type = {(state_q == FC2), 7'h40};
    tx_hdr  = ADV_P_H;
    tx_data = ADV_P_D;
    case (idx_q)
      2'd0:    begin tx_type[5:4] = 2'b00; tx_hdr = ADV_P_H;   tx_data = ADV_P_D;   end
      2'd1:    begin tx_type[5:4] = 2'b01; tx_hdr = ADV_NP_H;  tx_data = ADV_NP_D;  end
      default: begin tx_type[5:4] = 2'b10; tx_hdr = ADV_CPL_H; tx_data = ADV_CPL_D; end
    endcase
  end

  assign tx_dllp_o = tx_dllp_valid_o ? {tx_type, 2'b00, tx_hdr, 2'b00, tx_data} : 32'h0;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    seq_sent_d = seq_sent_q;
    rx_p_d     = rx_p_q;
    rx_np_d    = rx_np_q;
    rx_cpl_d   = rx_cpl_q;
    fc2_seen_d = fc2_seen_q;
    p_h_d      = p_h_q;
    p_d_d      = p_d_q;
    np_h_d     = np_h_q;
    np_d_d     = np_d_q;
    cpl_h_d    = cpl_h_q;
    cpl_d_d    = cpl_d_q;

    case (state_q)
      IDLE:    if (dlcm_state_i == 2'd1) state_d = FC1;
      FC1:     if (dlcm_state_i == 2'd2) state_d = FC2;
      FC2:     if (dlcm_state_i == 2'd3) state_d = DONE;
      default: state_d = state_q;
    endcase

    if ((state_q == FC1) || (state_q == FC2)) begin
      if (gap_q != '0) gap_d = gap_q - 1'b1;
      if (tx_fire) begin
        if (idx_q == 2'd2) begin
          idx_d      = 2'd0;
          seq_sent_d = 1'b1;
          gap_d      = GW'(RESEND_GAP);
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    end

    // Only the first InitFC of each type sets the limit; duplicates are ignored.
    if ((state_q == FC1) && rx_dllp_valid_i) begin
      case (rx_type)
        8'h40, 8'hC0: if (!rx_p_q) begin
          rx_p_d = 1'b1; p_h_d = rx_hdr; p_d_d = rx_data;
        end
        8'h50, 8'hD0: if (!rx_np_q) begin
          rx_np_d = 1'b1; np_h_d = rx_hdr; np_d_d = rx_data;
        end
        8'h60, 8'hE0: if (!rx_cpl_q) begin
          rx_cpl_d = 1'b1; cpl_h_d = rx_hdr; cpl_d_d = rx_data;
        end
        default: ;
      endcase
    end

    if (state_q == FC2) begin
      if (rx_tlp_i) fc2_seen_d = 1'b1;
      if (rx_dllp_valid_i) begin
        case (rx_type)
          8'hC0, 8'hD0, 8'hE0, 8'h80, 8'h90, 8'hA0: fc2_seen_d = 1'b1;
          default: ;
        endcase
      end
    end

    if ((state_q == FC1) && (state_d == FC2)) begin
      idx_d      = 2'd0;
      seq_sent_d = 1'b0;
      gap_d      = '0;
    end

    init1_d = (state_d == FC1) && (init1_q ||
              ((state_q == FC1) && rx_p_q && rx_np_q && rx_cpl_q && seq_sent_q));
    init2_d = (state_d == FC2) && (init2_q ||
              ((state_q == FC2) && fc2_seen_q && seq_sent_q));

    if (dlcm_state_i == 2'd0) begin
      state_d    = IDLE;
      idx_d      = 2'd0;
      gap_d      = '0;
      seq_sent_d = 1'b0;
      rx_p_d     = 1'b0;
      rx_np_d    = 1'b0;
      rx_cpl_d   = 1'b0;
      fc2_seen_d = 1'b0;
      init1_d    = 1'b0;
      init2_d    = 1'b0;
      p_h_d      = '0;
      p_d_d      = '0;
      np_h_d     = '0;
      np_d_d     = '0;
      cpl_h_d    = '0;
      cpl_d_d    = '0;
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      gap_q      <= '0;
      seq_sent_q <= 1'b0;
      rx_p_q     <= 1'b0;
      rx_np_q    <= 1'b0;
      rx_cpl_q   <= 1'b0;
      fc2_seen_q <= 1'b0;
      init1_q    <= 1'b0;
      init2_q    <= 1'b0;
      p_h_q      <= '0;
      p_d_q      <= '0;
      np_h_q     <= '0;
      np_d_q     <= '0;
      cpl_h_q    <= '0;
      cpl_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      seq_sent_q <= seq_sent_d;
      rx_p_q     <= rx_p_d;
      rx_np_q    <= rx_np_d;
      rx_cpl_q   <= rx_cpl_d;
      fc2_seen_q <= fc2_seen_d;
      init1_q    <= init1_d;
      init2_q    <= init2_d;
      p_h_q      <= p_h_d;
      p_d_q      <= p_d_d;
      np_h_q     <= np_h_d;
      np_d_q     <= np_d_d;
      cpl_h_q    <= cpl_h_d;
      cpl_d_q    <= cpl_d_d;
    end
  end

  assign init1_end_o = init1_q;
  assign init2_end_o = init2_q;
  assign p_h_lim_o   = p_h_q;
  assign p_d_lim_o   = p_d_q;
  assign np_h_lim_o  = np_h_q;
  assign np_d_lim_o  = np_d_q;
  assign cpl_h_lim_o = cpl_h_q;
  assign cpl_d_lim_o = cpl_d_q;

endmodule

// File: tb/tb_dll_fc_init.sv
// tb/tb_dll_fc_init.sv - Self-checking bench for dll_fc_init.
// Expected TX DLLPs are queued with the stimulus and popped at each handshake.
module tb_dll_fc_init;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic [1:0]  dlcm_state;
  logic        rx_dllp_valid;
  logic [31:0] rx_dllp;
  logic        rx_tlp;
  logic        tx_dllp_valid;
  logic [31:0] tx_dllp;
  logic        tx_dllp_ready;
  logic        init1_end, init2_end;
  logic [7:0]  p_h_lim, np_h_lim, cpl_h_lim;
  logic [11:0] p_d_lim, np_d_lim, cpl_d_lim;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] FC1_P   = 32'h4008_0100;
  localparam logic [31:0] FC1_NP  = 32'h5008_0000;
  localparam logic [31:0] FC1_CPL = 32'h6000_0000;
  localparam logic [31:0] FC2_P   = 32'hC008_0100;
  localparam logic [31:0] FC2_NP  = 32'hD008_0000;
  localparam logic [31:0] FC2_CPL = 32'hE000_0000;

  always #5 sclk = ~sclk;

  dll_fc_init dut (
    .sclk            (sclk),
    .srst_n          (srst_n),
    .dlcm_state_i    (dlcm_state),
    .rx_dllp_valid_i (rx_dllp_valid),
    .rx_dllp_i       (rx_dllp),
    .rx_tlp_i        (rx_tlp),
    .tx_dllp_valid_o (tx_dllp_valid),
    .tx_dllp_o       (tx_dllp),
    .tx_dllp_ready_i (tx_dllp_ready),
    .init1_end_o     (init1_end),
    .init2_end_o     (init2_end),
    .p_h_lim_o       (p_h_lim),
    .np_h_lim_o      (np_h_lim),
    .cpl_h_lim_o     (cpl_h_lim),
    .p_d_lim_o       (p_d_lim),
    .np_d_lim_o      (np_d_lim),
    .cpl_d_lim_o     (cpl_d_lim)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    return {t, 2'b00, h, 2'b00, d};
  endfunction

  task automatic send_dllp(input logic [31:0] d);
    rx_dllp       = d;
    rx_dllp_valid = 1'b1;
    step();
    rx_dllp_valid = 1'b0;
    rx_dllp       = 32'h0;
  endtask

  always @(negedge sclk) begin
    if (srst_n && tx_dllp_valid && tx_dllp_ready) begin
      check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_tx_dllp", tx_dllp, exp_q.pop_front());
    end
  end

  initial begin
    srst_n        = 1'b0;
    dlcm_state    = 2'd0;
    rx_dllp_valid = 1'b0;
    rx_dllp       = 32'h0;
    rx_tlp        = 1'b0;
    tx_dllp_ready = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_valid", 32'(tx_dllp_valid), 32'd0);
    check("rst_data", tx_dllp, 32'h0);
    check("rst_init", {30'd0, init1_end, init2_end}, 32'd0);
    check("rst_lims", {p_h_lim, np_h_lim, cpl_h_lim, 8'd0}, 32'd0);
    check("rst_dlims", {p_d_lim, np_d_lim, cpl_d_lim[7:0]}, 32'd0);
    srst_n = 1'b1;
    step();

    // FC1 sequence at full rate, then the resend gap
    dlcm_state    = 2'd1;
    tx_dllp_ready = 1'b1;
    exp_q.push_back(FC1_P);
    exp_q.push_back(FC1_NP);
    exp_q.push_back(FC1_CPL);
    step();
    check("fc1_first_valid", 32'(tx_dllp_valid), 32'd1);
    check("fc1_first_data", tx_dllp, FC1_P);
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      check("gap_valid_low", 32'(tx_dllp_valid), 32'd0);
      step();
    end
    check("resend_valid", 32'(tx_dllp_valid), 32'd1);
    check("resend_data", tx_dllp, FC1_P);
    tx_dllp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_data", tx_dllp, FC1_P);
    end
    check("sb_drained_fc1", 32'(exp_q.size()), 32'd0);

    // partner InitFC1 credits
    send_dllp(mk(8'h40, 8'h10, 12'h080));
    send_dllp(mk(8'h51, 8'h77, 12'h777));
    check("vc1_ignored", 32'(np_h_lim), 32'd0);
    send_dllp(mk(8'h50, 8'h04, 12'h000));
    check("init1_before_cpl", 32'(init1_end), 32'd0);
    send_dllp(mk(8'h60, 8'h00, 12'h000));
    check("init1_latency", 32'(init1_end), 32'd0);
    step();
    check("init1_set", 32'(init1_end), 32'd1);
    check("p_h_lim", 32'(p_h_lim), 32'h10);
    check("p_d_lim", 32'(p_d_lim), 32'h080);
    check("np_h_lim", 32'(np_h_lim), 32'h04);
    send_dllp(mk(8'h40, 8'h20, 12'h111));
    check("dup_p_h_lim", 32'(p_h_lim), 32'h10);
    check("dup_p_d_lim", 32'(p_d_lim), 32'h080);
    check("init1_held", 32'(init1_end), 32'd1);

    // FC2: fresh sequence starts at P right away
    dlcm_state = 2'd2;
    step();
    check("fc2_valid", 32'(tx_dllp_valid), 32'd1);
    check("fc2_first_data", tx_dllp, FC2_P);
    check("init1_cleared", 32'(init1_end), 32'd0);
    exp_q.push_back(FC2_P);
    exp_q.push_back(FC2_NP);
    exp_q.push_back(FC2_CPL);
    tx_dllp_ready = 1'b1;
    repeat (3) step();
    tx_dllp_ready = 1'b0;
    check("fc2_gap_valid", 32'(tx_dllp_valid), 32'd0);
    check("sb_drained_fc2", 32'(exp_q.size()), 32'd0);
    send_dllp(mk(8'hC1, 8'h01, 12'h001));
    step();
    check("init2_vc1_ignored", 32'(init2_end), 32'd0);
    rx_tlp = 1'b1;
    step();
    rx_tlp = 1'b0;
    check("init2_latency", 32'(init2_end), 32'd0);
    step();
    check("init2_set", 32'(init2_end), 32'd1);
    send_dllp(mk(8'hC0, 8'h7F, 12'hFFF));
    check("fc2_no_lim_update", 32'(p_h_lim), 32'h10);

    // DONE: quiet TX, limits retained
    dlcm_state    = 2'd3;
    tx_dllp_ready = 1'b1;
    step();
    check("done_valid", 32'(tx_dllp_valid), 32'd0);
    check("done_init2", 32'(init2_end), 32'd0);
    send_dllp(mk(8'h40, 8'h55, 12'h555));
    step();
    check("done_p_h_lim", 32'(p_h_lim), 32'h10);
    check("done_p_d_lim", 32'(p_d_lim), 32'h080);
    check("done_np_h_lim", 32'(np_h_lim), 32'h04);

    // drop to INACTIVE, then abort mid-FC1 handshake
    dlcm_state    = 2'd0;
    tx_dllp_ready = 1'b0;
    step();
    check("inactive_p_h_lim", 32'(p_h_lim), 32'd0);
    dlcm_state = 2'd1;
    step();
    send_dllp(mk(8'hD0, 8'h05, 12'h0AB));
    check("fc2code_np_h", 32'(np_h_lim), 32'h05);
    check("fc2code_np_d", 32'(np_d_lim), 32'h0AB);
    check("abort_pre_valid", 32'(tx_dllp_valid), 32'd1);
    dlcm_state = 2'd0;
    step();
    check("abort_valid", 32'(tx_dllp_valid), 32'd0);
    check("abort_lims", {p_h_lim, np_h_lim, cpl_h_lim, 8'd0}, 32'd0);
    check("abort_dlims", {p_d_lim, np_d_lim, cpl_d_lim[7:0]}, 32'd0);
    check("abort_init1", 32'(init1_end), 32'd0);
    dlcm_state = 2'd1;
    step();
    check("reenter_valid", 32'(tx_dllp_valid), 32'd1);
    check("reenter_data", tx_dllp, FC1_P);
    exp_q.push_back(FC1_P);
    tx_dllp_ready = 1'b1;
    step();
    tx_dllp_ready = 1'b0;
    check("reenter_next", tx_dllp, FC1_NP);
    check("sb_drained_end", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
